// File: rtl/fxp_mult_pkg.sv
// Shared types and constants for the sequential fixed-point multiplier.
// Widths are fixed at Q15.16 operands producing a Q32.32 product.
package fxp_mult_pkg;

  localparam int WIDTH = 32;
  localparam int FRAC  = 16;
  localparam int ITER  = WIDTH;
  localparam int CNT_W = $clog2(ITER);
  localparam int SR_W  = 16;

  localparam logic [WIDTH-1:0] MIN_NEG   = 32'h8000_0000;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLAG
  } state_t;

endpackage

// File: rtl/seq_fxp_multiplier_if.sv
// Handshake and result bundle between the filter sequencer (master)
// and the sequential multiplier (slave).
interface seq_fxp_multiplier_if;
  import fxp_mult_pkg::*;

  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic [SR_W-1:0]    signedResult;
  logic               overflowHigh;
  logic               overflowShift;
  logic               sign;

  modport master (
    output start, a, b,
    input  busy, done, result, signedResult, overflowHigh, overflowShift, sign
  );

  modport slave (
    input  start, a, b,
    output busy, done, result, signedResult, overflowHigh, overflowShift, sign
  );

endinterface

// File: rtl/fxp_abs.sv
// Combinational two's-complement magnitude; the most negative value maps
// onto itself, which reads correctly when treated as unsigned.
module fxp_abs
  import fxp_mult_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] value,
  output logic [W-1:0] magnitude
);

  always_comb begin
    magnitude = value[W-1] ? ('0 - value) : value;
  end

endmodule

// File: rtl/seq_fxp_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per cycle over the
// operand magnitudes, with sign and overflow flags for outSelector.
module seq_fxp_multiplier
  import fxp_mult_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  seq_fxp_multiplier_if.slave bus
);

  state_t             state;
  logic [WIDTH-1:0]   amag;
  logic [WIDTH-1:0]   bmag;
  logic [2*WIDTH-1:0] multiplicand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   multiplier;
  logic [CNT_W-1:0]   itercnt;
  logic               ovshiftq;
  logic               signq;

  logic               busyr;
  logic               doner;
  logic [2*WIDTH-1:0] resultr;
  logic [SR_W-1:0]    signedr;
  logic               ovhighr;
  logic               ovshiftr;
  logic               signr;

  logic [WIDTH-1:0]   midword;
  logic [SR_W-1:0]    negupper;

  fxp_abs #(.W(WIDTH)) u_abs_a (
    .value     (bus.a),
    .magnitude (amag)
  );

  fxp_abs #(.W(WIDTH)) u_abs_b (
    .value     (bus.b),
    .magnitude (bmag)
  );

  // Upper half of (0 - midword): ~x + 1 carries into the upper half only
  // when the lower half is all zeros.
  always_comb begin
    midword  = acc[WIDTH+FRAC-1:FRAC];
    negupper = ~midword[WIDTH-1:WIDTH-SR_W]
               + {{(SR_W-1){1'b0}}, (midword[WIDTH-SR_W-1:0] == '0)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      multiplicand <= '0;
      acc          <= '0;
      multiplier   <= '0;
      itercnt      <= '0;
      ovshiftq     <= 1'b0;
      signq        <= 1'b0;
      busyr        <= 1'b0;
      doner        <= 1'b0;
      resultr      <= '0;
      signedr      <= '0;
      ovhighr      <= 1'b0;
      ovshiftr     <= 1'b0;
      signr        <= 1'b0;
    end else begin
      doner <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            multiplicand <= {{WIDTH{1'b0}}, amag};
            multiplier   <= bmag;
            acc          <= '0;
            itercnt      <= '0;
            ovshiftq     <= (bus.a == MIN_NEG) || (bus.b == MIN_NEG);
            // A zero operand yields a zero product, which must read as positive.
            signq        <= (bus.a != '0) && (bus.b != '0) && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            busyr        <= 1'b1;
            state        <= RUN;
          end
        end
        RUN: begin
          if (multiplier[0]) begin
            acc <= acc + multiplicand;
          end
          multiplicand <= multiplicand << 1;
          multiplier   <= multiplier >> 1;
          itercnt      <= itercnt + CNT_W'(1);
          if (itercnt == LAST_ITER) begin
            state <= FLAG;
          end
        end
        FLAG: begin
          resultr  <= acc;
          ovhighr  <= |acc[2*WIDTH-1:WIDTH+FRAC-1];
          ovshiftr <= ovshiftq;
          signr    <= signq;
          signedr  <= negupper;
          doner    <= 1'b1;
          busyr    <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy          = busyr;
  assign bus.done          = doner;
  assign bus.result        = resultr;
  assign bus.signedResult  = signedr;
  assign bus.overflowHigh  = ovhighr;
  assign bus.overflowShift = ovshiftr;
  assign bus.sign          = signr;

endmodule

// File: tb/tb_seq_fxp_multiplier.sv
// Self-checking bench: directed vector table, handshake/reset sequences and
// randomized operands checked against a plain-arithmetic product model.
module tb_seq_fxp_multiplier;
  import fxp_mult_pkg::*;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic [15:0] sr;
    logic        ovh;
    logic        ovs;
    logic        sgn;
  } vec_t;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  logic [63:0] heldResult;

  seq_fxp_multiplier_if mif ();

  seq_fxp_multiplier dut (
    .clk (clk),
    .rst (rst),
    .bus (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: magnitudes multiplied with native 64-bit arithmetic.
  function automatic vec_t model(input logic [31:0] a, input logic [31:0] b);
    vec_t        v;
    logic [63:0] ma;
    logic [63:0] mb;
    logic [31:0] mid;
    logic [31:0] neg;
    ma = a[31] ? {32'd0, 32'(-a)} : {32'd0, a};
    mb = b[31] ? {32'd0, 32'(-b)} : {32'd0, b};
    v.a   = a;
    v.b   = b;
    v.res = ma * mb;
    mid   = v.res[47:16];
    neg   = 32'd0 - mid;
    v.sr  = neg[31:16];
    v.ovh = (v.res[63:47] != 17'd0);
    v.ovs = (a == 32'h8000_0000) || (b == 32'h8000_0000);
    v.sgn = (a != 0 && b != 0) ? (a[31] ^ b[31]) : 1'b0;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkResult(input string tag, input vec_t e);
    checkOutput({tag, ".result"}, mif.result, e.res);
    checkOutput({tag, ".signedResult"}, 64'(mif.signedResult), 64'(e.sr));
    checkOutput({tag, ".overflowHigh"}, 64'(mif.overflowHigh), 64'(e.ovh));
    checkOutput({tag, ".overflowShift"}, 64'(mif.overflowShift), 64'(e.ovs));
    checkOutput({tag, ".sign"}, 64'(mif.sign), 64'(e.sgn));
    checkOutput({tag, ".busy_at_done"}, 64'(mif.busy), 64'd0);
  endtask

  // One multiply from an idle DUT; returns after the cycle where done is seen.
  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b);
    int   lat;
    logic got;
    mif.a     = a;
    mif.b     = b;
    mif.start = 1'b1;
    tick();
    mif.start = 1'b0;
    mif.a     = $urandom;
    mif.b     = $urandom;
    checkOutput({tag, ".busy_after_accept"}, 64'(mif.busy), 64'd1);
    checkOutput({tag, ".done_after_accept"}, 64'(mif.done), 64'd0);
    checkOutput({tag, ".hold_during_run"}, mif.result, heldResult);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      tick();
      lat++;
      if (mif.done) got = 1'b1;
    end
    checkOutput({tag, ".latency"}, 64'(lat), 64'd33);
  endtask

  vec_t table_v[7];
  vec_t e;
  int   lat;
  int   extra;
  logic got;

  initial begin
    compared   = 0;
    mismatched = 0;
    heldResult = '0;

    table_v[0] = '{a:32'h0001_8000, b:32'h0002_0000, res:64'h0000_0003_0000_0000, sr:16'hFFFD, ovh:0, ovs:0, sgn:0};
    table_v[1] = '{a:32'hFFFE_8000, b:32'h0002_0000, res:64'h0000_0003_0000_0000, sr:16'hFFFD, ovh:0, ovs:0, sgn:1};
    table_v[2] = '{a:32'h0100_0000, b:32'h0080_0000, res:64'h0000_8000_0000_0000, sr:16'h8000, ovh:1, ovs:0, sgn:0};
    table_v[3] = '{a:32'h8000_0000, b:32'h0001_0000, res:64'h0000_8000_0000_0000, sr:16'h8000, ovh:1, ovs:1, sgn:1};
    table_v[4] = '{a:32'h0000_0000, b:32'hFFFB_0000, res:64'h0000_0000_0000_0000, sr:16'h0000, ovh:0, ovs:0, sgn:0};
    table_v[5] = '{a:32'h8000_0000, b:32'h8000_0000, res:64'h4000_0000_0000_0000, sr:16'h0000, ovh:1, ovs:1, sgn:0};
    table_v[6] = '{a:32'hFFFF_FFFF, b:32'h0001_0000, res:64'h0000_0000_0001_0000, sr:16'hFFFF, ovh:0, ovs:0, sgn:1};

    rst       = 1'b1;
    mif.start = 1'b0;
    mif.a     = '0;
    mif.b     = '0;
    repeat (3) tick();
    checkOutput("reset.busy", 64'(mif.busy), 64'd0);
    checkOutput("reset.done", 64'(mif.done), 64'd0);
    checkOutput("reset.result", mif.result, 64'd0);
    checkOutput("reset.flags", {61'd0, mif.overflowHigh, mif.overflowShift, mif.sign}, 64'd0);
    rst = 1'b0;
    tick();

    // Directed table, issued back to back (start in the cycle after done).
    for (int i = 0; i < 7; i++) begin
      applyStimulus($sformatf("vec%0d", i), table_v[i].a, table_v[i].b);
      checkResult($sformatf("vec%0d", i), table_v[i]);
      heldResult = table_v[i].res;
    end
    tick();
    checkOutput("done_one_cycle", 64'(mif.done), 64'd0);
    checkOutput("hold_after_done", mif.result, heldResult);

    // A start during a run is dropped, not queued.
    mif.a     = 32'h0001_8000;
    mif.b     = 32'h0002_0000;
    mif.start = 1'b1;
    tick();
    mif.start = 1'b0;
    got = 1'b0;
    lat = 100;
    for (int c = 1; c <= 100 && !got; c++) begin
      mif.start = (c == 10);
      if (c == 10) begin
        mif.a = 32'h0005_0000;
        mif.b = 32'h0007_0000;
      end
      tick();
      if (mif.done) begin
        got = 1'b1;
        lat = c;
      end
    end
    mif.start = 1'b0;
    checkOutput("busy_start.latency", 64'(lat), 64'd33);
    checkOutput("busy_start.result", mif.result, 64'h0000_0003_0000_0000);
    extra = 0;
    repeat (40) begin
      tick();
      if (mif.done) extra++;
    end
    checkOutput("busy_start.no_queued_done", 64'(extra), 64'd0);
    heldResult = 64'h0000_0003_0000_0000;

    // Reset in the middle of a run abandons it.
    mif.a     = 32'h0100_0000;
    mif.b     = 32'h0080_0000;
    mif.start = 1'b1;
    tick();
    mif.start = 1'b0;
    extra = 0;
    repeat (20) begin
      tick();
      if (mif.done) extra++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midreset.busy", 64'(mif.busy), 64'd0);
    checkOutput("midreset.result", mif.result, 64'd0);
    checkOutput("midreset.signedResult", 64'(mif.signedResult), 64'd0);
    checkOutput("midreset.flags", {61'd0, mif.overflowHigh, mif.overflowShift, mif.sign}, 64'd0);
    repeat (40) begin
      tick();
      if (mif.done) extra++;
    end
    checkOutput("midreset.no_done", 64'(extra), 64'd0);
    heldResult = '0;
    applyStimulus("after_reset", 32'h0001_8000, 32'h0002_0000);
    checkResult("after_reset", table_v[0]);
    heldResult = table_v[0].res;

    // Randomized operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] specials[4];
      specials[0] = 32'h0000_0000;
      specials[1] = 32'h8000_0000;
      specials[2] = 32'h0001_0000;
      specials[3] = 32'hFFFF_0000;
      case ($urandom_range(0, 3))
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = 32'($signed($urandom_range(0, 20'hFFFFF)) - 32'sh0008_0000);
                 rb = 32'($signed($urandom_range(0, 20'hFFFFF)) - 32'sh0008_0000); end
        2: begin ra = specials[$urandom_range(0, 3)]; rb = $urandom; end
        default: begin ra = $urandom; rb = specials[$urandom_range(0, 3)]; end
      endcase
      e = model(ra, rb);
      applyStimulus($sformatf("rand%0d", i), ra, rb);
      checkResult($sformatf("rand%0d", i), e);
      heldResult = e.res;
    end
    tick();
    checkOutput("final.done_low", 64'(mif.done), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seq_fxp_multiplier.md
Name: seq_fxp_multiplier

Overview:
- Iterative shift-add multiplier for the IIR filter's fixed-point datapath.
- Takes two two's-complement Q15.16 operands and multiplies their magnitudes one bit per cycle.
- Directly feeds outSelector with result, signedResult, overflowHigh, overflowShift and sign.
- One multiply in flight at a time; start/busy/done handshake toward the filter sequencer.

Parameters:
- WIDTH, 32, operand width in bits (two's complement).
- FRAC, 16, fractional bits per operand.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- a  input  WIDTH  operand A, Q15.16.
- b  input  WIDTH  operand B, Q15.16.
- busy  output  1  high from the accept edge until done.
- done  output  1  one-cycle pulse; outputs below are valid from this cycle.
- result  output  2*WIDTH  unsigned product |a|*|b|, Q32.32.
- signedResult  output  16  upper 16 bits of the 32-bit two's complement of result[47:16].
- overflowHigh  output  1  result[63:47] nonzero.
- overflowShift  output  1  either operand equals 0x80000000.
- sign  output  1  result sign.

Behaviour:
- Reset: on rst high at a clock edge, state goes to IDLE. All outputs and internal registers clear to 0. This applies in any state; a multiply in progress is abandoned and no done is produced.
- States: IDLE -> RUN -> FLAG -> IDLE.
- IDLE:
  - start=1 at edge k latches |a| into the multiplicand register (zero-extended to 2*WIDTH) and |b| into the multiplier register.
  - The same edge clears the accumulator, clears the iteration counter, sets busy=1 and moves to RUN.
  - a and b may change after edge k.
- RUN:
  - Each edge: if multiplier[0]=1, the accumulator adds the multiplicand.
  - Multiplicand shifts left 1; multiplier shifts right 1; counter increments.
  - After 32 iterations (edges k+1..k+32) the state moves to FLAG.
- FLAG, edge k+33:
  - result takes the accumulator value.
  - overflowHigh = |accumulator[63:47]|.
  - overflowShift = (a_in==0x80000000) or (b_in==0x80000000), from copies registered at k.
  - sign = a[31]^b[31], forced to 0 when either operand is zero.
  - signedResult = bits[31:16] of (32'd0 - accumulator[47:16]).
  - done=1, busy=0, state returns to IDLE.
- Latency: done is asserted exactly 33 cycles after the start-accept edge. done deasserts on the next edge.
- Output hold: result, signedResult and all flags keep their value until the next FLAG edge or reset. Starting a new multiply does not clear them.
- start is ignored while busy; such a request is dropped, not queued.
- A start issued in the cycle after done (state IDLE) is accepted, giving back-to-back throughput of one multiply per 34 cycles.
- Magnitude of 0x80000000 is 0x80000000 unsigned. The product is still computed, and overflowShift flags it so outSelector saturates.
- Arithmetic:
  - Accumulator width is 2*WIDTH; no carry is lost, since the maximum product is 2^62.
  - abs() is a two's-complement negate when bit 31 is set.
- Widths are fixed at WIDTH=32, FRAC=16 for this release. Other values need the overflow slice indices generalised to [2*WIDTH-1 : WIDTH+FRAC-1].

Decomposition:
- Package fxp_mult_pkg holds:
  - state enum {IDLE, RUN, FLAG};
  - constants WIDTH=32, FRAC=16 and ITER=WIDTH;
  - constant MIN_NEG=32'h8000_0000.
- One sub-module: fxp_abs (combinational two's-complement magnitude of a WIDTH-bit value), instantiated twice.

Test Plan:
- a=0x00018000 (1.5), b=0x00020000 (2.0), start one cycle:
  - done 33 cycles after accept;
  - result=0x0000_0003_0000_0000, sign=0, overflowHigh=0, overflowShift=0.
- a=0xFFFE8000 (-1.5), b=0x00020000:
  - result=0x0000_0003_0000_0000, sign=1, signedResult=0xFFFD;
  - downstream outSelector out=0xFFFD0000 (-3.0).
- a=0x01000000 (256.0), b=0x00800000 (128.0):
  - result=0x0000_8000_0000_0000, overflowHigh=1, sign=0.
- a=0x80000000, b=0x00010000 -> overflowShift=1, result=0x0000_8000_0000_0000.
- a=0x00000000, b=0xFFFB0000 (-5.0) -> result=0, sign=0, signedResult=0x0000.
- Handshake and reset:
  - start pulsed at cycle 10 of a run -> ignored, single done at 33.
  - rst asserted at cycle 20 of a run -> busy=0, all outputs 0, no done.
  - A following 1.5*2.0 then completes correctly.
